counting_src: RTL

Stimulus source for the 2-bit symbol stream consumed by the pattern detector (trigger sequence 01 → 10 → 11). Accepts burst commands over a valid/ready handshake. Each burst emits a programmable number of pseudo-random filler symbols, then optionally the trigger sequence. Filler can never form the trigger by construction. Drives the detector's `num` input directly, one symbol per clock, and serves as the on-chip stimulus and loopback source for detector testing.

---
 rtl/counting_pkg.sv | 32 +++
 rtl/counting_lfsr.sv | 30 +++
 rtl/counting_src.sv | 122 ++++++++++++
 3 files changed

// File: rtl/counting_pkg.sv
// Shared types and constants for the counting_src stimulus source.
// Symbol encodings match the pattern detector's 2-bit num input.
package counting_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StT1,
    StT2,
    StT3
  } state_e;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_T1   = 2'b01;
  localparam logic [1:0] SYM_T2   = 2'b10;
  localparam logic [1:0] SYM_T3   = 2'b11;

  localparam int unsigned LFSR_W = 8;
  // Feedback taps: q[7] ^ q[5] ^ q[4] ^ q[3]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
  endfunction

  // 11 is folded onto 00 so filler can never complete the trigger.
  function automatic logic [1:0] filler_sym(input logic [LFSR_W-1:0] q);
    return (q[1:0] == SYM_T3) ? SYM_IDLE : q[1:0];
  endfunction

endpackage

// File: rtl/counting_lfsr.sv
// 8-bit Fibonacci LFSR with synchronous seed load and shift enable.
// o_q_next is the value the register takes at the coming edge.
module counting_lfsr
  import counting_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_shift,
  output logic [LFSR_W-1:0] o_q,
  output logic [LFSR_W-1:0] o_q_next
);

  logic [LFSR_W-1:0] r_q;
  logic [LFSR_W-1:0] w_shifted;

  assign w_shifted = {r_q[LFSR_W-2:0], ^(r_q & LFSR_TAPS)};
  assign o_q_next  = i_shift ? w_shifted : r_q;
  assign o_q       = r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= lfsr_seed(SEED);
    end else begin
      r_q <= o_q_next;
    end
  end

endmodule

// File: rtl/counting_src.sv
// Burst stimulus source for the 01->10->11 pattern detector: pseudo-random
// filler symbols followed by an optional trigger sequence, one symbol per clock.
module counting_src
  import counting_pkg::*;
#(
  parameter logic [7:0]  SEED  = 8'hA5,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_trig,
  output logic [1:0]       num,
  output logic             busy,
  output logic             done,
  output logic [7:0]       trig_cnt
);

  state_e             r_state, w_state_d;
  logic [LEN_W-1:0]   r_rem, w_rem_d;
  logic               r_trig, w_trig_d;
  logic [1:0]         r_num, w_num_d;
  logic               r_done, w_done_d;
  logic [7:0]         r_trig_cnt;
  logic               w_accept;
  logic               w_shift;
  logic [LFSR_W-1:0]  w_lfsr_q;
  logic [LFSR_W-1:0]  w_lfsr_next;

  assign cmd_ready = (r_state == StIdle);
  assign busy      = ~cmd_ready;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_shift   = (r_state == StFill);
  assign num       = r_num;
  assign done      = r_done;
  assign trig_cnt  = r_trig_cnt;

  counting_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_shift  (w_shift),
    .o_q      (w_lfsr_q),
    .o_q_next (w_lfsr_next)
  );

  always_comb begin
    w_state_d = r_state;
    w_rem_d   = r_rem;
    w_trig_d  = r_trig;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_rem_d  = cmd_len;
          w_trig_d = cmd_trig;
          if (cmd_len != '0) begin
            w_state_d = StFill;
          end else if (cmd_trig) begin
            w_state_d = StT1;
          end
        end
      end
      StFill: begin
        w_rem_d = r_rem - 1'b1;
        if (r_rem == LEN_W'(1)) begin
          w_state_d = r_trig ? StT1 : StIdle;
        end
      end
      StT1:    w_state_d = StT2;
      StT2:    w_state_d = StT3;
      StT3:    w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so num always matches r_state;
  // w_lfsr_next is the LFSR value that will be current during that next cycle.
  always_comb begin
    w_num_d  = SYM_IDLE;
    w_done_d = 1'b0;
    unique case (w_state_d)
      StFill: begin
        w_num_d  = filler_sym(w_lfsr_next);
        w_done_d = (w_rem_d == LEN_W'(1)) && !w_trig_d;
      end
      StT1: w_num_d = SYM_T1;
      StT2: w_num_d = SYM_T2;
      StT3: begin
        w_num_d  = SYM_T3;
        w_done_d = 1'b1;
      end
      default: w_num_d = SYM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rem      <= '0;
      r_trig     <= 1'b0;
      r_num      <= SYM_IDLE;
      r_done     <= 1'b0;
      r_trig_cnt <= 8'h00;
    end else begin
      r_state <= w_state_d;
      r_rem   <= w_rem_d;
      r_trig  <= w_trig_d;
      r_num   <= w_num_d;
      r_done  <= w_done_d;
      if ((r_state == StT3) && (r_trig_cnt != 8'hFF)) begin
        r_trig_cnt <= r_trig_cnt + 8'h01;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^w_lfsr_q;

endmodule
